keccak_absorb_unit: RTL

// - Upstream neighbour of the suffix padder. Accepts message words over valid/ready and emits
//   per-lane XOR commands to the Keccak state register.
// - Counts bytes absorbed within the current rate block. Requests a permutation when the block
//   is full, and hands the final partial-block byte count to the padder.
// - Sequences FIPS 202 absorb: full blocks -> pad -> final permutation -> done.

---
 rtl/keccak_pkg.sv | 35 +++
 rtl/keccak_absorb_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/keccak_pkg.sv
// Shared Keccak absorb-path definitions.
//   - Lane / rate / byte-count widths used by the absorb unit and its neighbours.
//   - absorb_state_t: absorb sequencer states.
//   - byte_mask(): builds a lane-wide mask that keeps the lowest `keep` bytes.
package keccak_pkg;

    localparam int unsigned LANE_SIZE         = 64;
    localparam int unsigned LANE_BYTES        = 8;
    localparam int unsigned RATE_WIDTH        = 11;  // rates up to 1600 bits
    localparam int unsigned BYTE_ABSORB_WIDTH = 8;   // bytes per block up to 200
    localparam int unsigned KEEP_WIDTH        = 4;
    localparam int unsigned LANE_IDX_WIDTH    = 5;

    typedef enum logic [2:0] {
        IDLE,
        ABSORB,
        PERM,
        WAIT_PERM,
        PAD,
        DONE
    } absorb_state_t;

    // Bytes 0..keep-1 set to 0xFF, higher bytes zero; keep >= 8 gives all ones.
    function automatic logic [LANE_SIZE-1:0] byte_mask(input logic [KEEP_WIDTH-1:0] keep);
        logic [LANE_SIZE-1:0] mask;
        mask = '0;
        for (int unsigned b = 0; b < LANE_BYTES; b++) begin
            if (b < 32'(keep)) begin
                mask[b*8 +: 8] = '1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/keccak_absorb_unit.sv
// Keccak absorb sequencer.
// Accepts little-endian 64-bit message words over valid/ready, issues per-lane
// XOR commands to the state register, tracks the byte count inside the current
// rate block, requests permutations on full blocks, and drives the padder with
// the final partial-block byte count. Sequence: full blocks -> pad -> final
// permutation -> done.
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   start_i, rate_i   begin a message (IDLE only); rate in bits latched on start
//   msg_*             message word stream (keep honoured only on last word)
//   xor_en_o, xor_lane_idx_o, xor_data_o   lane XOR command (combinational)
//   pad_en_o, bytes_absorbed_o             padder capture strobe / byte count
//   perm_start_o, perm_done_i              permutation request / completion
//   done_o            one-cycle absorb-finished pulse
module keccak_absorb_unit
    import keccak_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_i,
    input  logic [RATE_WIDTH-1:0]        rate_i,
    input  logic [LANE_SIZE-1:0]         msg_data_i,
    input  logic [KEEP_WIDTH-1:0]        msg_keep_i,
    input  logic                         msg_last_i,
    input  logic                         msg_valid_i,
    output logic                         msg_ready_o,
    output logic                         xor_en_o,
    output logic [LANE_IDX_WIDTH-1:0]    xor_lane_idx_o,
    output logic [LANE_SIZE-1:0]         xor_data_o,
    output logic                         pad_en_o,
    output logic [BYTE_ABSORB_WIDTH-1:0] bytes_absorbed_o,
    output logic                         perm_start_o,
    input  logic                         perm_done_i,
    output logic                         done_o
);

    absorb_state_t                state_q, state_d;
    logic [BYTE_ABSORB_WIDTH-1:0] count_q, count_d;
    logic [RATE_WIDTH-1:0]        rate_q, rate_d;
    logic                         pad_pend_q, pad_pend_d;
    logic                         final_q, final_d;

    logic                         accept;
    logic [KEEP_WIDTH-1:0]        n_bytes;
    logic [BYTE_ABSORB_WIDTH-1:0] count_sum;
    logic                         block_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            rate_q     <= '0;
            pad_pend_q <= 1'b0;
            final_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rate_q     <= rate_d;
            pad_pend_q <= pad_pend_d;
            final_q    <= final_d;
        end
    end

    // Datapath: byte count of the offered word and the resulting block fill.
    always_comb begin
        msg_ready_o = (state_q == ABSORB);
        accept      = msg_valid_i && msg_ready_o;

        if (!msg_last_i) begin
            n_bytes = KEEP_WIDTH'(LANE_BYTES);
        end else if (msg_keep_i > KEEP_WIDTH'(LANE_BYTES)) begin
            n_bytes = KEEP_WIDTH'(LANE_BYTES);
        end else begin
            n_bytes = msg_keep_i;
        end

        count_sum = count_q + BYTE_ABSORB_WIDTH'(n_bytes);
        // Block is full when count*8 reaches the latched rate in bits.
        block_full = ({count_sum, 3'b000} == rate_q);

        // An empty tail (keep=0 on last) is accepted but produces no XOR.
        xor_en_o       = accept && (n_bytes != '0);
        xor_lane_idx_o = count_q[BYTE_ABSORB_WIDTH-1:3];
        xor_data_o     = xor_en_o ? (msg_data_i & byte_mask(n_bytes)) : '0;

        bytes_absorbed_o = count_q;
        pad_en_o         = (state_q == PAD);
        perm_start_o     = (state_q == PERM);
        done_o           = (state_q == DONE);
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        rate_d     = rate_q;
        pad_pend_d = pad_pend_q;
        final_d    = final_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d    = ABSORB;
                    count_d    = '0;
                    rate_d     = rate_i;
                    pad_pend_d = 1'b0;
                    final_d    = 1'b0;
                end
            end

            ABSORB: begin
                if (accept) begin
                    if (n_bytes == '0) begin
                        // Only reachable on the last word: nothing to absorb.
                        state_d = PAD;
                    end else begin
                        count_d = count_sum;
                        if (block_full) begin
                            // A last word that exactly fills the block still needs
                            // a fresh padded block after this permutation.
                            state_d    = PERM;
                            pad_pend_d = msg_last_i;
                        end else if (msg_last_i) begin
                            state_d = PAD;
                        end
                    end
                end
            end

            PERM: begin
                state_d = WAIT_PERM;
            end

            WAIT_PERM: begin
                if (perm_done_i) begin
                    count_d = '0;
                    if (pad_pend_q) begin
                        state_d    = PAD;
                        pad_pend_d = 1'b0;
                    end else if (final_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = ABSORB;
                    end
                end
            end

            PAD: begin
                final_d = 1'b1;
                state_d = PERM;
            end

            DONE: begin
                final_d = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
